regfile_debug_access: RTL and testbench

REGFILE_DEBUG_ACCESS -- requirements
Module: regfile_debug_access

---
 rtl/regfile_debug_access.sv | 141 ++++++++++++++
 tb/tb_regfile_debug_access.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_debug_access.sv
// Debug access port for the integer register file.
// A debug command halts the core, performs one register read or write
// while the core is stalled, then holds the response until it is consumed.
// Optional feature: define DEBUG_HALT_TIMEOUT_EN to abort a command with
// rsp_error=1 when halt_ack does not arrive within HALT_TIMEOUT cycles.
module regfile_debug_access #(
  parameter int XLEN         = 32,
  parameter int HALT_TIMEOUT = 255
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [4:0]      cmd_addr,
  input  logic [XLEN-1:0] cmd_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_error,
  output logic            halt_req,
  input  logic            halt_ack,
  output logic [4:0]      rf_read_reg,
  input  logic [XLEN-1:0] rf_read_data,
  output logic [4:0]      rf_write_reg,
  output logic [XLEN-1:0] rf_write_data,
  output logic            rf_write_enable
);

  typedef enum logic [1:0] {IDLE, HALT, ACCESS, RESP} state_t;

  state_t            state;
  state_t            state_next;
  logic              lat_write;
  logic [4:0]        lat_addr;
  logic [XLEN-1:0]   lat_wdata;
  logic              accept;
  logic              timeout;

  assign accept = cmd_valid && cmd_ready;

`ifdef DEBUG_HALT_TIMEOUT_EN
  localparam int CW = (HALT_TIMEOUT > 1) ? $clog2(HALT_TIMEOUT) : 1;

  logic [CW-1:0] wait_cnt;

  // Count unacknowledged HALT cycles; cleared whenever HALT is left
  always_ff @(posedge clock) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state == HALT && !halt_ack) begin
      wait_cnt <= wait_cnt + CW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Abort fires on the edge where the count reaches HALT_TIMEOUT, so an
  // unacknowledged HALT lasts exactly HALT_TIMEOUT cycles.
  assign timeout = (wait_cnt == CW'(HALT_TIMEOUT - 1));

  // Error flag: set on halt timeout, cleared by a completed access
  always_ff @(posedge clock) begin
    if (!reset) begin
      rsp_error <= 1'b0;
    end else if (state == ACCESS) begin
      rsp_error <= 1'b0;
    end else if (state == HALT && !halt_ack && timeout) begin
      rsp_error <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^HALT_TIMEOUT;
  assign timeout            = 1'b0;
  assign rsp_error          = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; halt_ack takes priority over a same-cycle timeout
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = HALT;
      HALT: begin
        if (halt_ack)     state_next = ACCESS;
        else if (timeout) state_next = RESP;
      end
      ACCESS:  state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs; register file ports are driven only in ACCESS
  always_comb begin
    cmd_ready       = (state == IDLE);
    halt_req        = (state == HALT) || (state == ACCESS);
    rsp_valid       = (state == RESP);
    rf_read_reg     = '0;
    rf_write_reg    = '0;
    rf_write_data   = '0;
    rf_write_enable = 1'b0;
    if (state == ACCESS) begin
      rf_read_reg     = lat_addr;
      rf_write_reg    = lat_addr;
      rf_write_data   = lat_wdata;
      rf_write_enable = lat_write && (lat_addr != 5'd0);
    end
  end

  // Command capture and response data
  always_ff @(posedge clock) begin
    if (!reset) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        lat_write <= cmd_write;
        lat_addr  <= cmd_addr;
        lat_wdata <= cmd_wdata;
      end
      if (state == ACCESS) begin
        rsp_rdata <= (!lat_write && lat_addr != 5'd0) ? rf_read_data : '0;
      end else if (state == HALT && !halt_ack && timeout) begin
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_debug_access.sv
// Self-checking bench for regfile_debug_access with a small register file
// model and a queue of expected responses.
module tb_regfile_debug_access;

  localparam int XLEN = 32;
`ifdef DEBUG_HALT_TIMEOUT_EN
  localparam int HT        = 8;
  localparam int ACK_DELAY = 6;
`else
  localparam int HT        = 255;
  localparam int ACK_DELAY = 10;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic            cmd_write = 1'b0;
  logic [4:0]      cmd_addr = '0;
  logic [XLEN-1:0] cmd_wdata = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_error;
  logic            halt_req;
  logic            halt_ack = 1'b1;
  logic [4:0]      rf_read_reg;
  logic [XLEN-1:0] rf_read_data;
  logic [4:0]      rf_write_reg;
  logic [XLEN-1:0] rf_write_data;
  logic            rf_write_enable;

  always #5 clock = ~clock;

  regfile_debug_access #(.XLEN(XLEN), .HALT_TIMEOUT(HT)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .halt_req(halt_req), .halt_ack(halt_ack),
    .rf_read_reg(rf_read_reg), .rf_read_data(rf_read_data),
    .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .rf_write_enable(rf_write_enable)
  );

  typedef struct packed {
    logic [XLEN-1:0] rdata;
    logic            error;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   we_count = 0;
  int   rsp_count = 0;

  logic [XLEN-1:0] rf_model [32];
  logic            force_rd = 1'b0;
  logic [XLEN-1:0] forced_val = '0;

  assign rf_read_data = force_rd ? forced_val : rf_model[rf_read_reg];

  initial begin
    for (int i = 0; i < 32; i++) rf_model[i] = '0;
  end

  always @(posedge clock) begin
    if (rf_write_enable) begin
      we_count++;
      if (rf_write_reg != 5'd0) rf_model[rf_write_reg] <= rf_write_data;
    end
    if (rsp_valid && rsp_ready) rsp_count++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one command from a negedge; returns at the negedge after acceptance.
  task automatic send_cmd(input logic w, input logic [4:0] a, input logic [XLEN-1:0] d,
                          input logic push, input logic [XLEN-1:0] exp_rd, input logic exp_er);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1 || n != 0) begin
      failures++;
      $display("FAIL cmd_accept cmd_ready=%b wait=%0d exp ready immediately", cmd_ready, n);
    end
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    if (push) exp_q.push_back('{rdata: exp_rd, error: exp_er});
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
  endtask

  // Wait (bounded) for rsp_valid, stall rsp_ready, then complete the handshake.
  task automatic collect(input int stall, output logic got, output logic [XLEN-1:0] rd,
                         output logic er, output logic stable, output int waited);
    waited = 0;
    stable = 1'b1;
    rsp_ready = 1'b0;
    while (!rsp_valid && waited < 400) begin
      @(negedge clock);
      waited++;
    end
    got = rsp_valid;
    rd  = rsp_rdata;
    er  = rsp_error;
    if (got) begin
      for (int i = 0; i < stall; i++) begin
        @(negedge clock);
        if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_error !== er) stable = 1'b0;
      end
      rsp_ready = 1'b1;
      @(negedge clock);
      rsp_ready = 1'b0;
    end
  endtask

  function automatic exp_t pop_exp();
    exp_t e;
    e = 'x;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || halt_req !== 1'b0 || rf_write_enable !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl ready=%b valid=%b halt=%b we=%b exp 1 0 0 0",
               cmd_ready, rsp_valid, halt_req, rf_write_enable);
    end
    checks++;
    if (rf_read_reg !== 5'd0 || rf_write_reg !== 5'd0 || rf_write_data !== '0) begin
      failures++;
      $display("FAIL reset_rf rreg=%h wreg=%h wdata=%h exp 0", rf_read_reg, rf_write_reg, rf_write_data);
    end
    checks++;
    if (rsp_rdata !== '0 || rsp_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_rsp rdata=%h error=%b exp 0 0", rsp_rdata, rsp_error);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release cmd_ready=%b exp 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    logic got, er, stable;
    logic [XLEN-1:0] rd;
    int waited, we0;
    exp_t e;
    we0 = we_count;
    halt_ack = 1'b1;
    send_cmd(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, '0, 1'b0);
    checks++;
    if (halt_req !== 1'b1 || rf_write_enable !== 1'b0) begin
      failures++;
      $display("FAIL write_halt halt_req=%b we=%b exp 1 0", halt_req, rf_write_enable);
    end
    @(negedge clock);
    checks++;
    if (rf_write_enable !== 1'b1 || rf_write_reg !== 5'd5 || rf_write_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL write_access we=%b reg=%0d data=%h exp 1 5 deadbeef",
               rf_write_enable, rf_write_reg, rf_write_data);
    end
    collect(0, got, rd, er, stable, waited);
    e = pop_exp();
    checks++;
    if (!got || waited != 1) begin
      failures++;
      $display("FAIL write_latency got=%b waited=%0d exp 1 1", got, waited);
    end
    checks++;
    if (rd !== e.rdata || er !== e.error) begin
      failures++;
      $display("FAIL write_rsp rdata=%h error=%b exp %h %b", rd, er, e.rdata, e.error);
    end
    checks++;
    if (we_count - we0 != 1) begin
      failures++;
      $display("FAIL write_strobes count=%0d exp 1", we_count - we0);
    end
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || halt_req !== 1'b0) begin
      failures++;
      $display("FAIL write_idle valid=%b ready=%b halt=%b exp 0 1 0", rsp_valid, cmd_ready, halt_req);
    end
  endtask

  task automatic test_read();
    logic got, er, stable;
    logic [XLEN-1:0] rd;
    int waited;
    exp_t e;
    force_rd = 1'b1;
    forced_val = 32'h12345678;
    send_cmd(1'b0, 5'd5, '0, 1'b1, 32'h12345678, 1'b0);
    @(negedge clock);
    checks++;
    if (rf_read_reg !== 5'd5 || rf_write_enable !== 1'b0) begin
      failures++;
      $display("FAIL read_access rreg=%0d we=%b exp 5 0", rf_read_reg, rf_write_enable);
    end
    collect(0, got, rd, er, stable, waited);
    e = pop_exp();
    checks++;
    if (!got || rd !== e.rdata || er !== e.error) begin
      failures++;
      $display("FAIL read5_rsp got=%b rdata=%h error=%b exp 1 %h %b", got, rd, er, e.rdata, e.error);
    end
    forced_val = 32'hFFFFFFFF;
    send_cmd(1'b0, 5'd0, '0, 1'b1, '0, 1'b0);
    collect(0, got, rd, er, stable, waited);
    e = pop_exp();
    checks++;
    if (!got || rd !== e.rdata || er !== e.error) begin
      failures++;
      $display("FAIL read0_rsp got=%b rdata=%h error=%b exp 1 %h %b", got, rd, er, e.rdata, e.error);
    end
    force_rd = 1'b0;
  endtask

  task automatic test_write_x0();
    logic got, er, stable;
    logic [XLEN-1:0] rd;
    int waited, we0;
    exp_t e;
    we0 = we_count;
    send_cmd(1'b1, 5'd0, 32'h1, 1'b1, '0, 1'b0);
    collect(0, got, rd, er, stable, waited);
    e = pop_exp();
    checks++;
    if (!got || rd !== e.rdata || er !== e.error) begin
      failures++;
      $display("FAIL x0_rsp got=%b rdata=%h error=%b exp 1 %h %b", got, rd, er, e.rdata, e.error);
    end
    checks++;
    if (we_count != we0) begin
      failures++;
      $display("FAIL x0_strobe count=%0d exp 0", we_count - we0);
    end
  endtask

  task automatic test_delayed_ack();
    logic got, er, stable;
    logic [XLEN-1:0] rd;
    int waited, hi;
    exp_t e;
    halt_ack = 1'b0;
    force_rd = 1'b1;
    forced_val = 32'hCAFEF00D;
    send_cmd(1'b0, 5'd9, '0, 1'b1, 32'hCAFEF00D, 1'b0);
    hi = 0;
    for (int i = 0; i < ACK_DELAY; i++) begin
      if (halt_req === 1'b1 && rsp_valid === 1'b0 && rf_read_reg === 5'd0) hi++;
      @(negedge clock);
    end
    checks++;
    if (hi != ACK_DELAY) begin
      failures++;
      $display("FAIL delay_halt_held cycles=%0d exp %0d", hi, ACK_DELAY);
    end
    halt_ack = 1'b1;
    @(negedge clock);
    checks++;
    if (rf_read_reg !== 5'd9 || halt_req !== 1'b1) begin
      failures++;
      $display("FAIL delay_access rreg=%0d halt=%b exp 9 1", rf_read_reg, halt_req);
    end
    halt_ack = 1'b0;
    collect(4, got, rd, er, stable, waited);
    halt_ack = 1'b1;
    e = pop_exp();
    checks++;
    if (!got || waited != 1 || rd !== e.rdata || er !== e.error) begin
      failures++;
      $display("FAIL delay_rsp got=%b waited=%0d rdata=%h error=%b exp 1 1 %h %b",
               got, waited, rd, er, e.rdata, e.error);
    end
    checks++;
    if (stable !== 1'b1) begin
      failures++;
      $display("FAIL delay_stall_stable stable=%b exp 1", stable);
    end
    force_rd = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic got, er, stable;
    logic [XLEN-1:0] rd;
    int waited;
    exp_t e;
    send_cmd(1'b1, 5'd10, 32'h0BADF00D, 1'b1, '0, 1'b0);
    collect(0, got, rd, er, stable, waited);
    send_cmd(1'b0, 5'd10, '0, 1'b1, 32'h0BADF00D, 1'b0);
    collect(0, got, rd, er, stable, waited);
    send_cmd(1'b0, 5'd5, '0, 1'b1, 32'hDEADBEEF, 1'b0);
    e = pop_exp();
    checks++;
    if (e.rdata !== '0 || e.error !== 1'b0) begin
      failures++;
      $display("FAIL b2b_queue_order rdata=%h exp 0", e.rdata);
    end
    e = pop_exp();
    checks++;
    if (!got || rd !== e.rdata || er !== e.error) begin
      failures++;
      $display("FAIL b2b_readback got=%b rdata=%h error=%b exp 1 %h %b", got, rd, er, e.rdata, e.error);
    end
    collect(0, got, rd, er, stable, waited);
    e = pop_exp();
    checks++;
    if (!got || rd !== e.rdata || er !== e.error) begin
      failures++;
      $display("FAIL b2b_read5 got=%b rdata=%h error=%b exp 1 %h %b", got, rd, er, e.rdata, e.error);
    end
  endtask

`ifdef DEBUG_HALT_TIMEOUT_EN
  task automatic test_timeout();
    logic got, er, stable;
    logic [XLEN-1:0] rd;
    int waited, we0;
    exp_t e;
    we0 = we_count;
    halt_ack = 1'b0;
    send_cmd(1'b1, 5'd4, 32'h55, 1'b1, '0, 1'b1);
    collect(0, got, rd, er, stable, waited);
    halt_ack = 1'b1;
    e = pop_exp();
    checks++;
    if (!got || waited != HT) begin
      failures++;
      $display("FAIL timeout_latency got=%b waited=%0d exp 1 %0d", got, waited, HT);
    end
    checks++;
    if (rd !== e.rdata || er !== e.error) begin
      failures++;
      $display("FAIL timeout_rsp rdata=%h error=%b exp %h %b", rd, er, e.rdata, e.error);
    end
    checks++;
    if (we_count != we0) begin
      failures++;
      $display("FAIL timeout_strobe count=%0d exp 0", we_count - we0);
    end
  endtask
`endif

  task automatic test_reset_mid_cmd();
    int we0, rc0;
    we0 = we_count;
    rc0 = rsp_count;
    halt_ack = 1'b0;
    send_cmd(1'b1, 5'd3, 32'h77, 1'b0, '0, 1'b0);
    checks++;
    if (halt_req !== 1'b1) begin
      failures++;
      $display("FAIL midrst_in_halt halt_req=%b exp 1", halt_req);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (cmd_ready !== 1'b1 || halt_req !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== '0) begin
      failures++;
      $display("FAIL midrst_idle ready=%b halt=%b valid=%b rdata=%h exp 1 0 0 0",
               cmd_ready, halt_req, rsp_valid, rsp_rdata);
    end
    reset = 1'b1;
    halt_ack = 1'b1;
    rsp_ready = 1'b1;
    repeat (5) @(negedge clock);
    rsp_ready = 1'b0;
    checks++;
    if (we_count != we0 || rsp_count != rc0 || rf_model[3] !== '0) begin
      failures++;
      $display("FAIL midrst_no_effect writes=%0d rsps=%0d x3=%h exp 0 0 0",
               we_count - we0, rsp_count - rc0, rf_model[3]);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d exp 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_write_x0();
    test_delayed_ack();
    test_back_to_back();
`ifdef DEBUG_HALT_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_cmd();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
